// File: rtl/sound_pkg.sv
// Shared constants and helpers for the square/pulse sound channels.
package sound_pkg;

  // Duty waveforms, MSB is duty step 0.
  localparam logic [7:0] DUTY_PATTERNS [4] = '{
    8'b0000_0001,
    8'b1000_0001,
    8'b1000_0111,
    8'b0111_1110
  };

  // Frame-sequencer steps (bit n set = unit clocks on step n).
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_t;

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    pat = DUTY_PATTERNS[duty];
    return pat[3'd7 - step];
  endfunction

  // 12-bit sweep target; bit 11 set means the result exceeds 2047.
  function automatic logic [11:0] sweep_calc(input logic [10:0] shadow,
                                             input logic [2:0]  shift,
                                             input logic        negate);
    logic [11:0] base;
    logic [11:0] delta;
    base  = {1'b0, shadow};
    delta = base >> shift;
    return negate ? (base - delta) : (base + delta);
  endfunction

endpackage

// File: rtl/pulse_channel_if.sv
// Register/strobe bundle between the APU register file and one pulse channel.
interface pulse_channel_if #(
  parameter int unsigned OUT_W = 24
);
  logic             frame_tick;
  logic [7:0]       nrx0;
  logic [7:0]       nrx1;
  logic [7:0]       nrx2;
  logic [7:0]       nrx3;
  logic [7:0]       nrx4;
  logic             trig;
  logic             len_wr;
  logic             freq_wr;
  logic [OUT_W-1:0] sample;
  logic             active;

  modport master (
    output frame_tick, nrx0, nrx1, nrx2, nrx3, nrx4, trig, len_wr, freq_wr,
    input  sample, active
  );

  modport slave (
    input  frame_tick, nrx0, nrx1, nrx2, nrx3, nrx4, trig, len_wr, freq_wr,
    output sample, active
  );
endinterface

// File: rtl/frame_sequencer.sv
// 8-step frame sequencer driven by the 512 Hz strobe; emits unit clock strobes.
module frame_sequencer
  import sound_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic len_clk,
  output logic sweep_clk,
  output logic env_clk
);

  logic [2:0] step_q;
  logic [2:0] step_d;

  // Advance the step on each tick; strobes fire for the step being entered.
  always_comb begin
    step_d    = step_q;
    len_clk   = 1'b0;
    sweep_clk = 1'b0;
    env_clk   = 1'b0;
    if (frame_tick) begin
      step_d    = step_q + 3'd1;
      len_clk   = LEN_STEPS[step_d];
      sweep_clk = SWEEP_STEPS[step_d];
      env_clk   = ENV_STEPS[step_d];
    end
  end

  // Step register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/pulse_channel.sv
// Square-wave channel: duty timer, length, envelope, optional sweep, registered sample.
module pulse_channel
  import sound_pkg::*;
#(
  parameter int unsigned OUT_W      = 24,
  parameter bit          SWEEP_EN   = 1'b1,
  parameter int unsigned TIMER_MULT = 4
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [7:0]       nrx0,
  input  logic [7:0]       nrx1,
  input  logic [7:0]       nrx2,
  input  logic [7:0]       nrx3,
  input  logic [7:0]       nrx4,
  input  logic             trig,
  input  logic             len_wr,
  input  logic             freq_wr,
  output logic [OUT_W-1:0] sample,
  output logic             active
);

  localparam int unsigned TMR_W = 12 + $clog2(TIMER_MULT);

  logic [10:0]      freq_q, freq_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       duty_step_q, duty_step_d;
  logic [6:0]       len_q, len_d;
  logic [3:0]       vol_q, vol_d;
  logic [2:0]       env_cnt_q, env_cnt_d;
  logic             active_q, active_d;
  logic [OUT_W-1:0] sample_q, sample_d;

  logic             len_clk, sweep_clk, env_clk;
  logic             len_expire;
  logic             sweep_upd, sweep_kill;
  logic [10:0]      sweep_freq;

  logic             dac_on;
  logic [10:0]      reg_freq;
  logic [2:0]       env_period;
  env_dir_t         env_dir;
  logic             unused_inputs;

  assign dac_on        = (nrx2[7:3] != '0);
  assign reg_freq      = {nrx4[2:0], nrx3};
  assign env_period    = nrx2[2:0];
  assign env_dir       = env_dir_t'(nrx2[3]);
  assign unused_inputs = ^{nrx0[7], nrx4[7], nrx4[5:3]};

  function automatic logic [TMR_W-1:0] period_of(input logic [10:0] f);
    logic [TMR_W-1:0] span;
    span = TMR_W'(12'd2048 - {1'b0, f});
    return span * TMR_W'(TIMER_MULT);
  endfunction

  frame_sequencer u_frame_seq (
    .clk        (system_clock),
    .rst_n      (reset),
    .frame_tick (frame_tick),
    .len_clk    (len_clk),
    .sweep_clk  (sweep_clk),
    .env_clk    (env_clk)
  );

  // Frequency register, frequency timer and duty step.
  always_comb begin
    freq_d      = freq_q;
    tmr_d       = tmr_q;
    duty_step_d = duty_step_q;
    if (trig || freq_wr) begin
      freq_d = reg_freq;
    end
    if (sweep_upd) begin
      freq_d = sweep_freq;
    end
    if (trig) begin
      tmr_d       = period_of(freq_d);
      duty_step_d = '0;
    end else if (tmr_q <= TMR_W'(1)) begin
      tmr_d       = period_of(freq_q);
      duty_step_d = duty_step_q + 3'd1;
    end else begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Length counter; a write lands before the trigger's zero-means-64 rule.
  always_comb begin
    len_d      = len_q;
    len_expire = 1'b0;
    if (len_wr) begin
      len_d = 7'd64 - {1'b0, nrx1[5:0]};
    end
    if (trig) begin
      if (len_d == '0) begin
        len_d = 7'd64;
      end
    end else if (!len_wr && len_clk && nrx4[6] && (len_q != '0)) begin
      len_d      = len_q - 7'd1;
      len_expire = (len_d == '0);
    end
  end

  // Volume envelope with saturation at both ends; period 0 freezes volume.
  always_comb begin
    vol_d     = vol_q;
    env_cnt_d = env_cnt_q;
    if (trig) begin
      vol_d     = nrx2[7:4];
      env_cnt_d = env_period;
    end else if (env_clk && (env_period != '0)) begin
      if (env_cnt_q <= 3'd1) begin
        env_cnt_d = env_period;
        if (env_dir == ENV_UP) begin
          if (vol_q != 4'hF) begin
            vol_d = vol_q + 4'd1;
          end
        end else if (vol_q != '0) begin
          vol_d = vol_q - 4'd1;
        end
      end else begin
        env_cnt_d = env_cnt_q - 3'd1;
      end
    end
  end

  // Channel enable: sweep overflow and DAC-off override a trigger in the same cycle.
  always_comb begin
    active_d = active_q;
    if (len_expire) begin
      active_d = 1'b0;
    end
    if (trig) begin
      active_d = 1'b1;
    end
    if (sweep_kill) begin
      active_d = 1'b0;
    end
    if (!dac_on) begin
      active_d = 1'b0;
    end
  end

  // Output sample from current state; registered below.
  always_comb begin
    sample_d = '0;
    if (active_q && duty_bit(nrx1[7:6], duty_step_q)) begin
      sample_d = OUT_W'(vol_q) << (OUT_W - 4);
    end
  end

  generate
    if (SWEEP_EN) begin : g_sweep
      logic [10:0] shadow_q, shadow_d;
      logic [3:0]  sw_tmr_q, sw_tmr_d;
      logic        sw_on_q, sw_on_d;
      logic [2:0]  sw_period;
      logic [2:0]  sw_shift;
      logic        sw_negate;
      logic [3:0]  sw_reload;
      logic [11:0] calc_trig, calc_cur, calc_next;

      assign sw_period = nrx0[6:4];
      assign sw_negate = nrx0[3];
      assign sw_shift  = nrx0[2:0];
      assign sw_reload = (sw_period == '0) ? 4'd8 : {1'b0, sw_period};

      // Sweep timer, shadow frequency and both overflow checks.
      always_comb begin
        shadow_d   = shadow_q;
        sw_tmr_d   = sw_tmr_q;
        sw_on_d    = sw_on_q;
        sweep_upd  = 1'b0;
        sweep_kill = 1'b0;
        sweep_freq = shadow_q;
        calc_trig  = sweep_calc(reg_freq, sw_shift, sw_negate);
        calc_cur   = sweep_calc(shadow_q, sw_shift, sw_negate);
        calc_next  = sweep_calc(calc_cur[10:0], sw_shift, sw_negate);
        if (trig) begin
          shadow_d = reg_freq;
          sw_tmr_d = sw_reload;
          sw_on_d  = (sw_period != '0) || (sw_shift != '0);
          if ((sw_shift != '0) && (calc_trig > 12'd2047)) begin
            sweep_kill = 1'b1;
          end
        end else if (sweep_clk) begin
          if (sw_tmr_q <= 4'd1) begin
            sw_tmr_d = sw_reload;
            if (sw_on_q && (sw_period != '0)) begin
              if (calc_cur > 12'd2047) begin
                sweep_kill = 1'b1;
              end else if (sw_shift != '0) begin
                shadow_d   = calc_cur[10:0];
                sweep_upd  = 1'b1;
                sweep_freq = calc_cur[10:0];
                if (calc_next > 12'd2047) begin
                  sweep_kill = 1'b1;
                end
              end
            end
          end else begin
            sw_tmr_d = sw_tmr_q - 4'd1;
          end
        end
      end

      // Sweep state registers.
      always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
          shadow_q <= '0;
          sw_tmr_q <= '0;
          sw_on_q  <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          sw_tmr_q <= sw_tmr_d;
          sw_on_q  <= sw_on_d;
        end
      end
    end else begin : g_no_sweep
      logic unused_sweep;
      assign unused_sweep = ^{nrx0, sweep_clk};
      assign sweep_upd    = 1'b0;
      assign sweep_kill   = 1'b0;
      assign sweep_freq   = '0;
    end
  endgenerate

  // Channel state and output registers.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      freq_q      <= '0;
      tmr_q       <= '0;
      duty_step_q <= '0;
      len_q       <= '0;
      vol_q       <= '0;
      env_cnt_q   <= '0;
      active_q    <= 1'b0;
      sample_q    <= '0;
    end else begin
      freq_q      <= freq_d;
      tmr_q       <= tmr_d;
      duty_step_q <= duty_step_d;
      len_q       <= len_d;
      vol_q       <= vol_d;
      env_cnt_q   <= env_cnt_d;
      active_q    <= active_d;
      sample_q    <= sample_d;
    end
  end

  assign sample = sample_q;
  assign active = active_q;

endmodule

// File: tb/tb_pulse_channel.sv
// Directed self-checking bench for pulse_channel with hand-computed expectations.
module tb_pulse_channel;

  localparam int unsigned OUT_W = 24;

  logic system_clock = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pulse_channel_if #(.OUT_W(OUT_W)) bus ();

  pulse_channel #(
    .OUT_W      (OUT_W),
    .SWEEP_EN   (1'b1),
    .TIMER_MULT (4)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .frame_tick   (bus.frame_tick),
    .nrx0         (bus.nrx0),
    .nrx1         (bus.nrx1),
    .nrx2         (bus.nrx2),
    .nrx3         (bus.nrx3),
    .nrx4         (bus.nrx4),
    .trig         (bus.trig),
    .len_wr       (bus.len_wr),
    .freq_wr      (bus.freq_wr),
    .sample       (bus.sample),
    .active       (bus.active)
  );

  always #5 system_clock = ~system_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge system_clock);
  endtask

  // One-cycle strobes, seen by exactly one rising edge.
  task automatic strobe(input logic t, input logic lw, input logic fw, input logic ft);
    @(negedge system_clock);
    bus.trig = t; bus.len_wr = lw; bus.freq_wr = fw; bus.frame_tick = ft;
    @(negedge system_clock);
    bus.trig = 1'b0; bus.len_wr = 1'b0; bus.freq_wr = 1'b0; bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) strobe(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_regs(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] r3, input logic [7:0] r4);
    bus.nrx0 = r0; bus.nrx1 = r1; bus.nrx2 = r2; bus.nrx3 = r3; bus.nrx4 = r4;
  endtask

  task automatic do_reset();
    bus.trig = 1'b0; bus.len_wr = 1'b0; bus.freq_wr = 1'b0; bus.frame_tick = 1'b0;
    set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
  endtask

  initial begin
    reset = 1'b0;

    // Reset state
    do_reset();
    check_eq("reset_active", 32'(bus.active), 32'h0);
    check_eq("reset_sample", 32'(bus.sample), 32'h0);

    // Square wave: freq 0x700, 50% duty, 1024 clocks per duty step
    set_regs(8'h00, 8'h80, 8'hF0, 8'h00, 8'h87);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sq_active", 32'(bus.active), 32'h1);
    cycles(1);
    check_eq("sq_t1_high", 32'(bus.sample), 32'hF00000);
    cycles(1023);
    check_eq("sq_t1024_high", 32'(bus.sample), 32'hF00000);
    cycles(1);
    check_eq("sq_t1025_low", 32'(bus.sample), 32'h0);
    cycles(4095);
    check_eq("sq_t5120_low", 32'(bus.sample), 32'h0);
    cycles(1);
    check_eq("sq_t5121_high", 32'(bus.sample), 32'hF00000);
    cycles(4095);
    check_eq("sq_t9216_high", 32'(bus.sample), 32'hF00000);
    cycles(1);
    check_eq("sq_t9217_low", 32'(bus.sample), 32'h0);

    // Length 62 -> counter 2, expires on the 2nd length clock (tick 4)
    do_reset();
    set_regs(8'h00, 8'h3E, 8'hF0, 8'h00, 8'hC7);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("len_trig_active", 32'(bus.active), 32'h1);
    ticks(3);
    check_eq("len_tick3_active", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("len_tick4_inactive", 32'(bus.active), 32'h0);
    cycles(1);
    check_eq("len_sample_off", 32'(bus.sample), 32'h0);

    // Retrigger with expired length loads 64: 64 length clocks = 128 ticks
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("len64_active", 32'(bus.active), 32'h1);
    ticks(127);
    check_eq("len64_tick127", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("len64_tick128", 32'(bus.active), 32'h0);

    // len_wr together with trig: 64-63 = 1, expires on first length clock
    do_reset();
    set_regs(8'h00, 8'h3F, 8'hF0, 8'h00, 8'hC7);
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("lwtrig_active", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("lwtrig_tick1", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("lwtrig_tick2", 32'(bus.active), 32'h0);

    // Envelope 0x3B: vol 3 up, period 3; freq 0 keeps duty step 0 (high)
    do_reset();
    set_regs(8'h00, 8'h80, 8'h3B, 8'h00, 8'h80);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_eq("env_vol3", 32'(bus.sample), 32'h300000);
    ticks(22);
    cycles(1);
    check_eq("env_tick22_vol3", 32'(bus.sample), 32'h300000);
    ticks(1);
    cycles(1);
    check_eq("env_tick23_vol4", 32'(bus.sample), 32'h400000);
    ticks(24);
    cycles(1);
    check_eq("env_tick47_vol5", 32'(bus.sample), 32'h500000);
    ticks(239);
    cycles(1);
    check_eq("env_tick286_vol14", 32'(bus.sample), 32'hE00000);
    ticks(1);
    cycles(1);
    check_eq("env_tick287_vol15", 32'(bus.sample), 32'hF00000);
    ticks(48);
    cycles(1);
    check_eq("env_saturate15", 32'(bus.sample), 32'hF00000);

    // Sweep overflow on trigger: 2032 + 1016 > 2047
    do_reset();
    set_regs(8'h11, 8'h80, 8'hF0, 8'hF0, 8'h87);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sweep_trig_kill", 32'(bus.active), 32'h0);
    cycles(1);
    check_eq("sweep_trig_sample", 32'(bus.sample), 32'h0);

    // Sweep 1024 -> 1536 on first sweep clock; second check 2304 kills
    do_reset();
    set_regs(8'h11, 8'h80, 8'hF0, 8'h00, 8'h84);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sweep_upd_active", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("sweep_upd_tick1", 32'(bus.active), 32'h1);
    ticks(1);
    check_eq("sweep_upd_tick2_kill", 32'(bus.active), 32'h0);

    // DAC off blocks trigger, and turns an active channel off
    do_reset();
    set_regs(8'h00, 8'h80, 8'h00, 8'h00, 8'h87);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("dac_off_trig", 32'(bus.active), 32'h0);
    cycles(1);
    check_eq("dac_off_sample", 32'(bus.sample), 32'h0);
    bus.nrx2 = 8'hF0;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("dac_on_trig", 32'(bus.active), 32'h1);
    bus.nrx2 = 8'h07;
    cycles(1);
    check_eq("dac_off_live", 32'(bus.active), 32'h0);

    // Asynchronous reset mid-envelope
    do_reset();
    set_regs(8'h00, 8'h80, 8'hF3, 8'h00, 8'h87);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    cycles(1);
    check_eq("rst_pre_sample", 32'(bus.sample), 32'hF00000);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_sample", 32'(bus.sample), 32'h0);
    check_eq("rst_async_active", 32'(bus.active), 32'h0);
    @(negedge system_clock);
    reset = 1'b1;
    cycles(20);
    check_eq("rst_silent_active", 32'(bus.active), 32'h0);
    check_eq("rst_silent_sample", 32'(bus.sample), 32'h0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_retrig_active", 32'(bus.active), 32'h1);
    cycles(1);
    check_eq("rst_retrig_sample", 32'(bus.sample), 32'hF00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
